// File: rtl/rr_arbiter_4_1.sv
// rtl/rr_arbiter_4_1.sv - four-source round-robin arbiter into a single registered output slot
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   per-source valid, bit i = source i
//   in_data    source i payload at [i*W +: W]
//   in_ready   per-source ready, one-hot or zero, combinational
//   out_valid  output slot holds an item
//   out_data   payload of the held item
//   out_sel    index of the source that supplied the held item
//   out_ready  downstream accepts the held item
module rr_arbiter_4_1 #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_sel,
  input  logic           out_ready
);

  logic [1:0] ptr;
  logic [1:0] grant;
  logic [1:0] idx;
  logic       found;
  logic       slot_free;
  logic       in_fire;

  // The slot may accept a new item when empty or when its item leaves this edge.
  assign slot_free = !out_valid || out_ready;

  // Scan starting at ptr; 2-bit index arithmetic gives the mod-4 wrap for free.
  always_comb begin
    grant = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign in_fire = found && slot_free && !rst;

  always_comb begin
    in_ready = 4'b0000;
    if (in_fire) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd0;
    end else if (in_fire) begin
      // Only the granted lane is read, so other lanes' contents never matter.
      out_data  <= in_data[grant*W +: W];
      out_sel   <= grant;
      out_valid <= 1'b1;
      ptr       <= grant + 2'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4_1.sv
// tb/tb_rr_arbiter_4_1.sv - randomized scoreboard bench for rr_arbiter_4_1
module tb_rr_arbiter_4_1;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     in_valid = 4'b0000;
  logic [4*W-1:0] in_data = '0;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready = 1'b0;

  rr_arbiter_4_1 #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: next source to favour, and whether the output slot is occupied.
  int  m_ptr   = 0;
  bit  m_valid = 1'b0;
  bit  m_known = 1'b0;
  logic [5:0] sb[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus: drive at the falling edge, predict, check in_ready, book the item.
  task automatic cycle(input logic r, input logic [3:0] v, input logic [15:0] d, input logic ordy);
    int g;
    logic [3:0] exp_ready;
    @(negedge clk);
    rst = r;
    in_valid = v;
    in_data = d;
    out_ready = ordy;
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    exp_ready = 4'b0000;
    if (!r && g >= 0 && (!m_valid || ordy)) exp_ready[g] = 1'b1;
    chk("in_ready", int'(in_ready), int'(exp_ready));
    if (m_known) chk("out_valid", int'(out_valid), int'(m_valid));
    if (r) begin
      m_valid = 1'b0;
      m_ptr = 0;
      m_known = 1'b1;
      sb.delete();
    end else if (exp_ready != 4'b0000) begin
      sb.push_back({2'(g), d[g*4 +: 4]});
      m_valid = 1'b1;
      m_ptr = (g + 1) % 4;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: whenever the held item is taken downstream, it must match the oldest booked item.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        chk("sb_has_item", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("mon_out_sel", int'(out_sel), int'(e[5:4]));
          chk("mon_out_data", int'(out_data), int'(e[3:0]));
        end
      end
    end
  end

  initial begin
    logic [15:0] rd;
    // Basic single grant after reset.
    cycle(1, 4'b0000, 16'h0000, 0);
    cycle(1, 4'b0000, 16'h0000, 0);
    cycle(0, 4'b0100, 16'h0C00, 1);
    chk("single_ready", int'(in_ready), 4);
    cycle(0, 4'b0000, 16'h0000, 0);
    chk("single_valid", int'(out_valid), 1);
    chk("single_data", int'(out_data), 12);
    chk("single_sel", int'(out_sel), 2);
    cycle(0, 4'b1111, 16'h1234, 1);
    chk("ptr_after_single", int'(in_ready), 8);

    // All four sources valid: strict 0,1,2,3 rotation, one item per cycle.
    cycle(1, 4'b0000, 16'h0000, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 4'b1111, 16'hDCBA, 1);
      chk("rotation", int'(in_ready), 1 << (i % 4));
    end

    // Backpressure: held item stays put and nothing is granted.
    cycle(1, 4'b0000, 16'h0000, 0);
    cycle(0, 4'b0010, 16'h0070, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 4'b1111, 16'($urandom), 0);
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_data", int'(out_data), 7);
      chk("bp_sel", int'(out_sel), 1);
    end
    cycle(0, 4'b1111, 16'h4321, 1);
    chk("bp_release", int'(in_ready), 4);

    // Wrap-around from ptr=3 to source 0.
    cycle(1, 4'b0000, 16'h0000, 0);
    cycle(0, 4'b0100, 16'h0300, 1);
    cycle(0, 4'b1001, 16'h5009, 1);
    chk("wrap_src3", int'(in_ready), 8);
    cycle(0, 4'b1001, 16'h5009, 1);
    chk("wrap_src0", int'(in_ready), 1);

    // Drain: slot empties, payload and select hold.
    cycle(0, 4'b0000, 16'h0000, 1);
    cycle(0, 4'b0000, 16'h0000, 0);
    chk("drain_valid", int'(out_valid), 0);
    chk("drain_data", int'(out_data), 9);
    chk("drain_sel", int'(out_sel), 0);

    // Reset discards a held item and restarts the scan at source 0.
    cycle(0, 4'b0100, 16'h0E00, 0);
    cycle(1, 4'b1111, 16'hFFFF, 0);
    chk("rst_ready", int'(in_ready), 0);
    cycle(0, 4'b0000, 16'h0000, 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sel", int'(out_sel), 0);
    cycle(0, 4'b1111, 16'h8765, 1);
    chk("rst_first_grant", int'(in_ready), 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rd = 16'($urandom);
      cycle(($urandom_range(0, 63) == 0), 4'($urandom), rd, ($urandom_range(0, 3) != 0));
    end

    // Drain anything outstanding, then the scoreboard must be empty.
    cycle(0, 4'b0000, 16'h0000, 1);
    cycle(0, 4'b0000, 16'h0000, 1);
    cycle(0, 4'b0000, 16'h0000, 1);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4_1.md
RR_ARBITER_4_1 -- requirements
Module: rr_arbiter_4_1

Interface
REQ-001 Parameter: W, default 4, data width of each input stream and of the output stream.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  4  per-source valid; bit i belongs to source i.
REQ-005 in_data  input  4*W  source i data at bits [i*W +: W].
REQ-006 in_ready  output  4  per-source ready; combinational; at most one bit high per cycle.
REQ-007 out_valid  output  1  registered output holds a valid item.
REQ-008 out_data  output  W  registered data of the held item.
REQ-009 out_sel  output  2  registered index of the source that supplied the held item; drives the downstream 4:1 mux select.
REQ-010 out_ready  input  1  downstream accepts the held item.

Function
REQ-011 Transfer on a port SHALL occur in a cycle where valid and ready are both high at the rising edge.
REQ-012 slot_free SHALL be (!out_valid || out_ready).
REQ-013 Grant SHALL be round-robin: scan sources ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first with in_valid high is granted.
REQ-014 in_ready[g] SHALL be high only for the granted source g, and only when slot_free; all other bits SHALL be 0.
REQ-015 With no in_valid bit high, in_ready SHALL be 4'b0000.
REQ-016 On an input transfer from source g: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= (g+1) mod 4.
REQ-017 On an output transfer with no simultaneous input transfer: out_valid <= 0; out_data and out_sel SHALL hold their values.
REQ-018 Simultaneous output and input transfer SHALL replace the held item in the same edge; out_valid stays 1 (throughput one item per cycle).
REQ-019 While out_valid=1 and out_ready=0: out_data, out_sel and out_valid SHALL be stable, and in_ready SHALL be 0.
REQ-020 ptr SHALL change only on an input transfer; it wraps 3 -> 0.
REQ-021 Latency SHALL be one cycle: an item accepted at edge N appears on out_* after edge N.
REQ-022 in_ready SHALL NOT depend combinationally on out_valid's next value, only on registered state, in_valid and out_ready.
REQ-023 Fairness: with all four sources continuously valid and out_ready=1, grants SHALL cycle 0,1,2,3,0,... with no source served twice before every other valid source is served once.
REQ-024 in_data of non-granted sources SHALL have no effect, including X values.

Reset
REQ-025 With rst high at a rising edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-026 During a cycle where rst is high, in_ready SHALL be 4'b0000 and no transfer SHALL be recorded.
REQ-027 Reset asserted while an item is held SHALL discard that item; first post-reset grant starts scan at source 0.

Verification
REQ-028 After reset, in_valid=4'b0100, in_data[2]=4'hC, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'hC, out_sel=2; ptr=3.
REQ-029 All sources valid with data A,B,C,D, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_data A,B,C,D repeating, one item per cycle.
REQ-030 Backpressure: item 4'h7 held from source 1, out_ready=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0, out_data=4'h7, out_sel=1 stable; on out_ready=1, source 2 granted same cycle.
REQ-031 ptr=3, in_valid=4'b1001 -> source 3 granted; next grant (in_valid still 4'b1001) -> source 0 (wrap-around).
REQ-032 Drain: held item, out_ready=1, in_valid=0 -> next cycle out_valid=0, out_data/out_sel unchanged.
REQ-033 rst asserted with out_valid=1, out_sel=2 -> next cycle out_valid=0, out_data=0, out_sel=0; with in_valid=4'b1111 the first grant is source 0.
